// File: rtl/ctr.sv
// Main control unit for the single-cycle MIPS CPU.
// Decodes the 6-bit opcode into datapath control signals.
// Every output is registered, so the outputs reflect the opcode seen at the
// most recent rising clock edge. An asynchronous active-low reset returns
// the block to the all-zero NOP word.
module ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opCode,
  output logic       regDst,
  output logic       aluSrc,
  output logic       memToReg,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       branch,
  output logic [1:0] aluop,
  output logic       jmp
);

  // Opcodes recognised by this control unit
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU-op classes handed to the ALU control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-state values of the control outputs
  logic       regDstNext;
  logic       aluSrcNext;
  logic       memToRegNext;
  logic       regWriteNext;
  logic       memReadNext;
  logic       memWriteNext;
  logic       branchNext;
  logic [1:0] aluopNext;
  logic       jmpNext;

  // Combinational opcode decode; fields that do not matter for an
  // instruction stay at 0 so no write enable is ever raised by accident,
  // and unknown opcodes fall through to the all-zero NOP word.
  always_comb begin
    regDstNext   = 1'b0;
    aluSrcNext   = 1'b0;
    memToRegNext = 1'b0;
    regWriteNext = 1'b0;
    memReadNext  = 1'b0;
    memWriteNext = 1'b0;
    branchNext   = 1'b0;
    aluopNext    = ALUOP_ADD;
    jmpNext      = 1'b0;
    case (opCode)
      OP_RTYPE: begin
        regDstNext   = 1'b1;
        regWriteNext = 1'b1;
        aluopNext    = ALUOP_FUNCT;
      end
      OP_LW: begin
        aluSrcNext   = 1'b1;
        memToRegNext = 1'b1;
        regWriteNext = 1'b1;
        memReadNext  = 1'b1;
      end
      OP_SW: begin
        aluSrcNext   = 1'b1;
        memWriteNext = 1'b1;
      end
      OP_BEQ: begin
        branchNext = 1'b1;
        aluopNext  = ALUOP_SUB;
      end
      OP_ADDI: begin
        aluSrcNext   = 1'b1;
        regWriteNext = 1'b1;
      end
      OP_J: begin
        jmpNext = 1'b1;
      end
      default: begin
        aluopNext = ALUOP_ADD;
      end
    endcase
  end

  // Output register: async clear to NOP, otherwise load the decoded word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regDst   <= 1'b0;
      aluSrc   <= 1'b0;
      memToReg <= 1'b0;
      regWrite <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      branch   <= 1'b0;
      aluop    <= ALUOP_ADD;
      jmp      <= 1'b0;
    end else begin
      regDst   <= regDstNext;
      aluSrc   <= aluSrcNext;
      memToReg <= memToRegNext;
      regWrite <= regWriteNext;
      memRead  <= memReadNext;
      memWrite <= memWriteNext;
      branch   <= branchNext;
      aluop    <= aluopNext;
      jmp      <= jmpNext;
    end
  end

endmodule

// File: tb/tb_ctr.sv
// Directed testbench for the MIPS main control unit.
// Observed word order: regDst, aluSrc, memToReg, regWrite, memRead,
// memWrite, branch, aluop[1:0], jmp.
module tb_ctr;

  logic       clk;
  logic       rst_n;
  logic [5:0] opCode;
  logic       regDst;
  logic       aluSrc;
  logic       memToReg;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       branch;
  logic [1:0] aluop;
  logic       jmp;

  logic [9:0] ctrlWord;
  assign ctrlWord = {regDst, aluSrc, memToReg, regWrite, memRead,
                     memWrite, branch, aluop, jmp};

  // Hand-computed control words from the decode table
  localparam logic [9:0] W_NOP  = 10'b0000000000;
  localparam logic [9:0] W_R    = 10'b1001000100;
  localparam logic [9:0] W_LW   = 10'b0111100000;
  localparam logic [9:0] W_SW   = 10'b0100010000;
  localparam logic [9:0] W_BEQ  = 10'b0000001010;
  localparam logic [9:0] W_ADDI = 10'b0101000000;
  localparam logic [9:0] W_J    = 10'b0000000001;

  int checkCount = 0;
  int passCount  = 0;

  ctr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opCode   (opCode),
    .regDst   (regDst),
    .aluSrc   (aluSrc),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .memRead  (memRead),
    .memWrite (memWrite),
    .branch   (branch),
    .aluop    (aluop),
    .jmp      (jmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table for the sweep
  function automatic logic [9:0] expectedFor(input logic [5:0] op);
    case (op)
      6'b000000: return W_R;
      6'b100011: return W_LW;
      6'b101011: return W_SW;
      6'b000100: return W_BEQ;
      6'b001000: return W_ADDI;
      6'b000010: return W_J;
      default:   return W_NOP;
    endcase
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    opCode = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_NOP)
      $display("FAIL reset_hold: got %b expected %b", ctrlWord, W_NOP);
    else passCount++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_R)
      $display("FAIL reset_release_rtype: got %b expected %b", ctrlWord, W_R);
    else passCount++;
    $display("reset: op=000000 word=%b", ctrlWord);
  endtask

  task automatic test_sequence();
    logic [5:0] ops  [5] = '{6'b000010, 6'b001000, 6'b100011, 6'b101011, 6'b000100};
    logic [9:0] exps [5] = '{W_J, W_ADDI, W_LW, W_SW, W_BEQ};
    for (int i = 0; i < 5; i++) begin
      opCode = ops[i];
      @(posedge clk);
      #1;
      checkCount++;
      if (ctrlWord !== exps[i])
        $display("FAIL seq_op_%b: got %b expected %b", ops[i], ctrlWord, exps[i]);
      else passCount++;
      $display("sequence: op=%b word=%b", ops[i], ctrlWord);
    end
  endtask

  task automatic test_undefined();
    logic [5:0] ops [2] = '{6'b111111, 6'b000001};
    for (int i = 0; i < 2; i++) begin
      opCode = ops[i];
      @(posedge clk);
      #1;
      checkCount++;
      if (ctrlWord !== W_NOP)
        $display("FAIL undef_op_%b: got %b expected %b", ops[i], ctrlWord, W_NOP);
      else passCount++;
      $display("undefined: op=%b word=%b", ops[i], ctrlWord);
    end
  endtask

  task automatic test_latency();
    opCode = 6'b100011;
    @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_LW)
      $display("FAIL latency_lw: got %b expected %b", ctrlWord, W_LW);
    else passCount++;
    #2 opCode = 6'b101011;
    #2;
    checkCount++;
    if (ctrlWord !== W_LW)
      $display("FAIL latency_hold: got %b expected %b", ctrlWord, W_LW);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_SW)
      $display("FAIL latency_switch: got %b expected %b", ctrlWord, W_SW);
    else passCount++;
    $display("latency: op=100011->101011 word=%b", ctrlWord);
  endtask

  task automatic test_async_reset();
    opCode = 6'b100011;
    @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_LW)
      $display("FAIL async_pre_lw: got %b expected %b", ctrlWord, W_LW);
    else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (ctrlWord !== W_NOP)
      $display("FAIL async_clear: got %b expected %b", ctrlWord, W_NOP);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_NOP)
      $display("FAIL async_hold: got %b expected %b", ctrlWord, W_NOP);
    else passCount++;
    opCode = 6'b101011;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if (ctrlWord !== W_SW)
      $display("FAIL async_release_sw: got %b expected %b", ctrlWord, W_SW);
    else passCount++;
    $display("async_reset: lw cleared, release loads sw word=%b", ctrlWord);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops  [4] = '{6'b101011, 6'b100011, 6'b000010, 6'b000100};
    logic [9:0] exps [4] = '{W_SW, W_LW, W_J, W_BEQ};
    for (int i = 0; i < 4; i++) begin
      opCode = ops[i];
      @(posedge clk);
      #1;
      checkCount++;
      if (ctrlWord !== exps[i])
        $display("FAIL b2b_op_%b: got %b expected %b", ops[i], ctrlWord, exps[i]);
      else passCount++;
      $display("back_to_back: op=%b word=%b", ops[i], ctrlWord);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] op;
    logic [9:0] exp;
    for (int i = 0; i < 64; i++) begin
      op = 6'(i);
      exp = expectedFor(op);
      opCode = op;
      @(posedge clk);
      #1;
      checkCount++;
      if (ctrlWord !== exp)
        $display("FAIL sweep_op_%b: got %b expected %b", op, ctrlWord, exp);
      else passCount++;
      checkCount++;
      if ((memRead && memWrite) || (memWrite && regWrite) ||
          (jmp && (branch || regWrite || memWrite)) || (aluop === 2'b11) ||
          ($isunknown(ctrlWord)))
        $display("FAIL sweep_invariant_op_%b: got %b expected no invariant violation", op, ctrlWord);
      else passCount++;
      $display("sweep: op=%b word=%b", op, ctrlWord);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opCode = 6'b000000;
    test_reset();
    test_sequence();
    test_undefined();
    test_latency();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ctr.md
Name: ctr

Overview:
- Main control unit of the single-cycle MIPS CPU (mipscpu).
- Decodes the 6-bit instruction opcode into datapath control signals: register-file destination and write, ALU source and ALU-op class, memory read/write, branch, jump.
- Outputs are registered: one clock, asynchronous active-low reset.
- Consumers are the register file, ALU control, data memory and PC-select logic.

Parameters:
- None. Opcode width is fixed at 6 and aluop width at 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opCode  input  6  instruction bits [31:26]
regDst  output  1  1 = write-register address from rd; 0 = from rt
aluSrc  output  1  1 = ALU operand B is the sign-extended immediate; 0 = register rt
memToReg  output  1  1 = register write-back data from data memory; 0 = from ALU
regWrite  output  1  register-file write enable
memRead  output  1  data-memory read enable
memWrite  output  1  data-memory write enable
branch  output  1  conditional branch (beq) qualifier, ANDed with ALU zero downstream
aluop  output  2  ALU-op class: 00 = add, 01 = subtract (compare), 10 = decode funct field, 11 unused
jmp  output  1  unconditional jump select

Behaviour:
- Reset:
  - rst_n low immediately (asynchronously) forces every output to 0, with aluop = 00. This is the NOP state.
  - Outputs hold at 0 while rst_n is low.
  - Release is sampled on the next rising clk.
- Latency:
  - Decode is combinational from opCode.
  - All outputs are registered on the rising edge of clk.
  - Outputs reflect the opCode present at the most recent rising edge, i.e. 1-cycle latency.
  - opCode changes between edges have no effect on outputs.
- Decode table, bit order regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluop, jmp:
  - 000000 R-type: 1,0,0,1,0,0,0,10,0
  - 100011 lw: 0,1,1,1,1,0,0,00,0
  - 101011 sw: 0,1,0,0,0,1,0,00,0
  - 000100 beq: 0,0,0,0,0,0,1,01,0
  - 001000 addi: 0,1,0,1,0,0,0,00,0
  - 000010 j: 0,0,0,0,0,0,0,00,1
  - Any other opcode: all outputs 0, aluop = 00 (NOP). The block never produces X.
- Don't-care fields are driven to 0 (e.g. regDst/memToReg for sw, beq and j) so that memory and register writes are never spuriously enabled.
- Invariants, checkable every cycle:
  - memRead and memWrite are never both 1.
  - memWrite = 1 implies regWrite = 0.
  - jmp = 1 implies branch = 0, regWrite = 0 and memWrite = 0.
  - At most one of branch and jmp is 1.
  - aluop = 11 is never produced.
- Back-to-back opcodes on consecutive edges each produce their own decode the following cycle, with no holdover.
- Reset asserted mid-stream clears the outputs at once. The first post-release edge loads the decode of the opCode present at that edge.

Test Plan:
- Reset: hold rst_n = 0 with opCode = 000000 and clock running -> all outputs 0, aluop = 00. Deassert; after the next edge -> regDst = 1, regWrite = 1, aluop = 10, all others 0.
- Sequence 000010, 001000, 100011, 101011, 000100, one per clock edge:
  - j -> jmp = 1, others 0.
  - addi -> aluSrc = 1, regWrite = 1, aluop = 00.
  - lw -> aluSrc = memToReg = regWrite = memRead = 1.
  - sw -> aluSrc = memWrite = 1, regWrite = 0.
  - beq -> branch = 1, aluop = 01.
  - Each response appears one edge after its opcode is applied.
- Undefined opcodes 111111 and 000001 -> all outputs 0, aluop = 00. The invariants hold.
- Latency: change opCode from 100011 to 101011 mid-cycle -> outputs keep the lw decode until the next rising edge, then switch to sw.
- Async reset: with lw decoded, pull rst_n low between edges -> outputs go to 0 immediately, without waiting for a clock edge.
- Sweep all 64 opcodes -> the 6 listed opcodes match the table; the other 58 give NOP; the invariants hold on every cycle.
